ifetch_mem_responder: RTL

Memory-side responder for the instruction cache's fetch interface. It accepts a single-outstanding fetch request (ic_asking/ic_addr), reads the instruction bytes from the byte-wide unified RAM port, and returns a 32-bit word with a one-cycle data_ready pulse. It detects RVC length from the first two bits and reads 2 or 4 bytes. It yields the RAM port to the load/store buffer before starting a fetch, and cancels in-flight fetches on flush.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/ifetch_mem_responder.sv | 107 ++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared states and constants for the instruction fetch responder.
package fetch_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    B0,
    B1,
    B2,
    B3,
    B4,
    RESP
  } fetch_state_t;
  localparam logic [1:0]  INSN_LEN32_TAG = 2'b11;
  localparam logic [15:0] RVC_UPPER_FILL = 16'h0;
endpackage

// File: rtl/ifetch_mem_responder.sv
// ifetch_mem_responder: fetches a 2- or 4-byte instruction over the byte RAM port for the icache.
module ifetch_mem_responder
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_asking,
  input  logic [31:0]       ic_addr,
  input  logic              flush,
  input  logic              lsb_mem_busy,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_rd,
  output logic              ic_busy,
  output logic [31:0]       data,
  output logic              data_ready
);
  fetch_state_t      state_q;
  logic [ADDR_W-1:0] addr_q, mem_a_q;
  logic [7:0]        b0_q, b1_q, b2_q;
  logic [31:0]       data_q;
  logic              mem_rd_q, ic_busy_q, data_ready_q;
  logic              unused_addr_hi;
  assign unused_addr_hi = &{1'b0, ic_addr[31:ADDR_W]};
  assign mem_a      = mem_a_q;
  assign mem_rd     = mem_rd_q;
  assign ic_busy    = ic_busy_q;
  assign data       = data_q;
  assign data_ready = data_ready_q;
  // Each byte arrives one cycle after its address, so captures trail issues by one state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      mem_a_q      <= '0;
      mem_rd_q     <= 1'b0;
      ic_busy_q    <= 1'b0;
      data_q       <= '0;
      data_ready_q <= 1'b0;
      b0_q         <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
    end else if (flush) begin
      state_q      <= IDLE;
      mem_rd_q     <= 1'b0;
      ic_busy_q    <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ic_asking) begin
          addr_q    <= ic_addr[ADDR_W-1:0];
          ic_busy_q <= 1'b1;
          if (lsb_mem_busy) state_q <= WAIT;
          else begin
            mem_a_q  <= ic_addr[ADDR_W-1:0];
            mem_rd_q <= 1'b1;
            state_q  <= B0;
          end
        end
        WAIT: if (!lsb_mem_busy) begin
          mem_a_q  <= addr_q;
          mem_rd_q <= 1'b1;
          state_q  <= B0;
        end
        B0: begin
          mem_a_q <= addr_q + ADDR_W'(1);
          state_q <= B1;
        end
        B1: begin
          b0_q    <= mem_din;
          mem_a_q <= addr_q + ADDR_W'(2);
          state_q <= B2;
        end
        B2: begin
          b1_q <= mem_din;
          if (b0_q[1:0] != INSN_LEN32_TAG) begin
            data_q       <= {RVC_UPPER_FILL, mem_din, b0_q};
            data_ready_q <= 1'b1;
            mem_rd_q     <= 1'b0;
            state_q      <= RESP;
          end else begin
            mem_a_q <= addr_q + ADDR_W'(3);
            state_q <= B3;
          end
        end
        B3: begin
          b2_q     <= mem_din;
          mem_rd_q <= 1'b0;
          state_q  <= B4;
        end
        B4: begin
          data_q       <= {mem_din, b2_q, b1_q, b0_q};
          data_ready_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          data_ready_q <= 1'b0;
          ic_busy_q    <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
